// File: rtl/ascon_inv_substitution_pkg.sv
// ascon_inv_substitution_pkg: shared types for the inverse substitution layer.
// Holds the 5x64 state type, FSM encoding and the inverse S-box table.
package ascon_inv_substitution_pkg;

  // x0 is row 0, x4 is row 4; bit j of each row forms column j
  typedef logic [0:4][63:0] type_state;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } inv_fsm_t;

  localparam logic [4:0] INV_SBOX [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

endpackage

// File: rtl/ascon_inv_substitution_inv_sbox.sv
// inv_sbox: inverse ASCON 5-bit S-box as a combinational lookup.
// Input/output bit 4 maps to row x0, bit 0 to row x4.
module inv_sbox (
  input  logic [4:0] din,
  output logic [4:0] dout
);

  // Table lookup of the inverse substitution
  always_comb begin
    dout = 5'h00;
    case (din)
      5'h00: dout = 5'h14;
      5'h01: dout = 5'h1a;
      5'h02: dout = 5'h07;
      5'h03: dout = 5'h0d;
      5'h04: dout = 5'h00;
      5'h05: dout = 5'h09;
      5'h06: dout = 5'h0e;
      5'h07: dout = 5'h12;
      5'h08: dout = 5'h0a;
      5'h09: dout = 5'h06;
      5'h0a: dout = 5'h1d;
      5'h0b: dout = 5'h01;
      5'h0c: dout = 5'h19;
      5'h0d: dout = 5'h15;
      5'h0e: dout = 5'h13;
      5'h0f: dout = 5'h1e;
      5'h10: dout = 5'h18;
      5'h11: dout = 5'h16;
      5'h12: dout = 5'h0b;
      5'h13: dout = 5'h11;
      5'h14: dout = 5'h03;
      5'h15: dout = 5'h05;
      5'h16: dout = 5'h1c;
      5'h17: dout = 5'h1f;
      5'h18: dout = 5'h17;
      5'h19: dout = 5'h1b;
      5'h1a: dout = 5'h04;
      5'h1b: dout = 5'h08;
      5'h1c: dout = 5'h0f;
      5'h1d: dout = 5'h0c;
      5'h1e: dout = 5'h10;
      5'h1f: dout = 5'h02;
      default: dout = 5'h00;
    endcase
  end

endmodule

// File: rtl/ascon_inv_substitution.sv
// ascon_inv_substitution: iterative inverse S-box layer over a 320-bit state.
// LANES columns are substituted in place per cycle under start/done control.
module ascon_inv_substitution
  import ascon_inv_substitution_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      start_i,
  input  type_state state_i,
  output logic      ready_o,
  output logic      busy_o,
  output logic      done_o,
  output type_state state_o
);

  localparam int NCHUNK = 64 / LANES;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LSH = $clog2(LANES);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16 || LANES == 32 ||
          LANES == 64)) begin : g_bad_lanes
      $error("LANES must be a power of two from 1 to 64");
    end
  endgenerate

  inv_fsm_t st_q;
  inv_fsm_t st_d;
  logic [CW-1:0] cnt_q;
  logic rdy_q;
  logic accept;
  logic last;
  logic [5:0] base;
  type_state work_q;
  logic [0:4][LANES-1:0] chunk_in;
  logic [0:4][LANES-1:0] chunk_out;

  assign accept = (st_q == IDLE) && rdy_q && start_i;
  assign last = (cnt_q == LAST);

  // First column of the chunk being processed
  always_comb begin
    base = 6'(cnt_q) << LSH;
  end

  // Gather the current chunk from every row
  always_comb begin
    chunk_in = '0;
    for (int r = 0; r < 5; r++) begin
      chunk_in[r] = work_q[r][base +: LANES];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [4:0] col_in;
    logic [4:0] col_out;

    assign col_in = {chunk_in[0][l], chunk_in[1][l],
                     chunk_in[2][l], chunk_in[3][l],
                     chunk_in[4][l]};

    inv_sbox u_sbox (
      .din (col_in),
      .dout(col_out)
    );

    assign chunk_out[0][l] = col_out[4];
    assign chunk_out[1][l] = col_out[3];
    assign chunk_out[2][l] = col_out[2];
    assign chunk_out[3][l] = col_out[1];
    assign chunk_out[4][l] = col_out[0];
  end

  // Next-state logic
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE: if (accept) st_d = RUN;
      RUN: if (last) st_d = DONE;
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // State, ready flag and chunk counter registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      st_q <= IDLE;
      rdy_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      rdy_q <= (st_d == IDLE);
      if (st_q == RUN) begin
        cnt_q <= last ? '0 : cnt_q + CW'(1);
      end else if (accept) begin
        cnt_q <= '0;
      end
    end
  end

  // Working register: load on accept, substitute one chunk per RUN cycle
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      work_q <= '0;
    end else if (accept) begin
      work_q <= state_i;
    end else if (st_q == RUN) begin
      for (int r = 0; r < 5; r++) begin
        work_q[r][base +: LANES] <= chunk_out[r];
      end
    end
  end

  assign ready_o = rdy_q;
  assign busy_o = (st_q == RUN);
  assign done_o = (st_q == DONE);
  assign state_o = work_q;

endmodule

// File: tb/tb_ascon_inv_substitution.sv
// tb_ascon_inv_substitution: randomized bench for three LANES variants.
// Results are compared against a column-wise table model of the S-box layer.
module tb_ascon_inv_substitution;
  import ascon_inv_substitution_pkg::*;

  localparam logic [4:0] INV_T [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };
  localparam logic [4:0] FWD_T [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [2:0] start;
  type_state sti;
  logic [2:0] rdy;
  logic [2:0] bsy;
  logic [2:0] dn;
  type_state so [3];

  int lat [3] = '{17, 65, 2};
  int n_chk = 0;
  int n_pass = 0;

  ascon_inv_substitution #(.LANES(4)) u_l4 (
    .clock_i(clk), .reset_i(rst), .start_i(start[0]),
    .state_i(sti), .ready_o(rdy[0]), .busy_o(bsy[0]),
    .done_o(dn[0]), .state_o(so[0])
  );

  ascon_inv_substitution #(.LANES(1)) u_l1 (
    .clock_i(clk), .reset_i(rst), .start_i(start[1]),
    .state_i(sti), .ready_o(rdy[1]), .busy_o(bsy[1]),
    .done_o(dn[1]), .state_o(so[1])
  );

  ascon_inv_substitution #(.LANES(64)) u_l64 (
    .clock_i(clk), .reset_i(rst), .start_i(start[2]),
    .state_i(sti), .ready_o(rdy[2]), .busy_o(bsy[2]),
    .done_o(dn[2]), .state_o(so[2])
  );

  task automatic check(input string tag,
                       input logic [319:0] got,
                       input logic [319:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // Apply the forward or inverse S-box to each of the 64 columns
  function automatic type_state sub(input type_state s, input bit inv);
    type_state r;
    logic [4:0] v;
    r = '0;
    for (int j = 0; j < 64; j++) begin
      v = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      v = inv ? INV_T[v] : FWD_T[v];
      for (int k = 0; k < 5; k++) r[k][j] = v[4-k];
    end
    return r;
  endfunction

  function automatic type_state rnd();
    type_state r;
    for (int i = 0; i < 5; i++) r[i] = {$urandom, $urandom};
    return r;
  endfunction

  // One transaction on all three variants; returns the LANES=4 result
  task automatic run_txn(input type_state s, input bit hold,
                         input string tag, output type_state r4);
    int dcyc [3];
    int npulse [3];
    type_state res [3];
    logic rdy_after [3];
    logic rdy_done [3];
    type_state exp;
    exp = sub(s, 1'b1);
    for (int i = 0; i < 3; i++) begin
      dcyc[i] = -1;
      npulse[i] = 0;
      res[i] = '0;
      rdy_after[i] = 1'b0;
      rdy_done[i] = 1'b1;
    end
    @(negedge clk);
    sti = s;
    start = '1;
    @(negedge clk);
    for (int k = 1; k <= 70; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (dn[i]) begin
          npulse[i]++;
          if (dcyc[i] < 0) begin
            dcyc[i] = k;
            res[i] = so[i];
            rdy_done[i] = rdy[i];
          end
        end
        if (dcyc[i] >= 0 && k == dcyc[i] + 1) rdy_after[i] = rdy[i];
      end
      if (hold) begin
        for (int i = 0; i < 3; i++) start[i] = (k < lat[i]);
        sti = rnd();
      end else begin
        start = '0;
      end
      @(negedge clk);
    end
    start = '0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_lat%0d", tag, i), 320'(dcyc[i]), 320'(lat[i]));
      check($sformatf("%s_pulses%0d", tag, i), 320'(npulse[i]), 320'(1));
      check($sformatf("%s_rdydone%0d", tag, i), 320'(rdy_done[i]), 320'(0));
      check($sformatf("%s_rdyafter%0d", tag, i), 320'(rdy_after[i]), 320'(1));
      check($sformatf("%s_res%0d", tag, i), res[i], exp);
    end
    r4 = res[0];
  endtask

  type_state s;
  type_state orig;
  type_state r;
  type_state kexp;
  int ndone;

  initial begin
    rst = 1'b1;
    start = '0;
    sti = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ready%0d", i), 320'(rdy[i]), 320'(0));
      check($sformatf("rst_busy%0d", i), 320'(bsy[i]), 320'(0));
      check($sformatf("rst_done%0d", i), 320'(dn[i]), 320'(0));
      check($sformatf("rst_state%0d", i), so[i], 320'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("rst_ready_up%0d", i), 320'(rdy[i]), 320'(1));

    // zero state: x0=x2=all ones
    run_txn('0, 1'b0, "zero", r);
    kexp = {64'hffff_ffff_ffff_ffff, 64'h0,
            64'hffff_ffff_ffff_ffff, 64'h0, 64'h0};
    check("zero_const", r, kexp);

    // forward S-box of zero inverts back to zero
    s = '0;
    s[2] = '1;
    run_txn(s, 1'b0, "fwd0", r);
    check("fwd0_const", r, 320'(0));

    // every S-box input appears in two columns
    for (int j = 0; j < 64; j++)
      for (int k = 0; k < 5; k++) s[k][j] = 1'((j % 32) >> (4 - k));
    run_txn(s, 1'b0, "table", r);

    // random round trips
    for (int t = 0; t < 3; t++) begin
      orig = rnd();
      run_txn(sub(orig, 1'b0), 1'b0, $sformatf("rt%0d", t), r);
      check($sformatf("rt%0d_orig", t), r, orig);
    end

    // start held high, inputs churning during RUN
    run_txn(rnd(), 1'b1, "hold", r);

    // reset in the middle of RUN
    @(negedge clk);
    sti = rnd();
    start = '1;
    @(negedge clk);
    start = '0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midrst_busy%0d", i), 320'(bsy[i]), 320'(0));
      check($sformatf("midrst_done%0d", i), 320'(dn[i]), 320'(0));
      check($sformatf("midrst_state%0d", i), so[i], 320'(0));
    end
    rst = 1'b0;
    ndone = 0;
    repeat (80) begin
      @(negedge clk);
      ndone += int'(dn[0]) + int'(dn[1]) + int'(dn[2]);
    end
    check("midrst_nodone", 320'(ndone), 320'(0));

    // simultaneous start and reset from idle: start is dropped
    @(negedge clk);
    sti = rnd();
    rst = 1'b1;
    start = '1;
    @(negedge clk);
    rst = 1'b0;
    start = '0;
    for (int i = 0; i < 3; i++)
      check($sformatf("rststart_busy%0d", i), 320'(bsy[i]), 320'(0));
    @(negedge clk);

    // fresh run after reset
    run_txn(rnd(), 1'b0, "fresh", r);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
